// File: rtl/comparator_bist.sv
// Exhaustive BIST sequencer for a W-bit magnitude comparator: sweeps every A/B pair, counts bad L/G/E codes.
// Optional CMP_BIST_FAIL_CAPTURE_EN builds registers holding the operands of the first failing vector.
module comparator_bist #(
    parameter int unsigned W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           L,
    input  logic           G,
    input  logic           E,
    output logic [W-1:0]   A,
    output logic [W-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [2*W:0]   err_count,
    output logic [W-1:0]   fail_a,
    output logic [W-1:0]   fail_b
);

    localparam int unsigned EW = 2 * W + 1;
    localparam logic [W-1:0]  OP_MAX  = '1;
    localparam logic [EW-1:0] ERR_MAX = EW'(1) << (2 * W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic [W-1:0]    a_nx, b_nx;
    logic [EW-1:0]   err_nx;
    logic            busy_nx, done_nx, pass_nx;
    logic            vec_fail;
    logic            accept;

    // Comparator response is combinational, so it is judged in the same cycle the vector is driven
    assign vec_fail = (L != (A < B)) || (G != (A > B)) || (E != (A == B));
    assign accept   = start && (state != RUN);

    always_comb begin
        state_nx = state;
        a_nx     = A;
        b_nx     = B;
        err_nx   = err_count;
        busy_nx  = busy;
        done_nx  = done;
        pass_nx  = pass;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = RUN;
                    a_nx     = '0;
                    b_nx     = '0;
                    err_nx   = '0;
                    busy_nx  = 1'b1;
                    done_nx  = 1'b0;
                    pass_nx  = 1'b0;
                end
            end
            RUN: begin
                if (vec_fail && (err_count != ERR_MAX)) begin
                    err_nx = err_count + EW'(1);
                end
                // Operands stop at all-ones on the last vector so they hold there in DONE
                if (B == OP_MAX) begin
                    if (A == OP_MAX) begin
                        state_nx = DONE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        pass_nx  = (err_nx == '0);
                    end else begin
                        b_nx = '0;
                        a_nx = A + W'(1);
                    end
                end else begin
                    b_nx = B + W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            A         <= '0;
            B         <= '0;
            err_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            state     <= state_nx;
            A         <= a_nx;
            B         <= b_nx;
            err_count <= err_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            pass      <= pass_nx;
        end
    end

`ifdef CMP_BIST_FAIL_CAPTURE_EN
    // A zero error count before this vector marks it as the first failure of the sweep
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fail_a <= '0;
            fail_b <= '0;
        end else if (accept) begin
            fail_a <= '0;
            fail_b <= '0;
        end else if ((state == RUN) && vec_fail && (err_count == '0)) begin
            fail_a <= A;
            fail_b <= B;
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign fail_a = '0;
    assign fail_b = '0;
`endif

endmodule

// File: tb/tb_comparator_bist.sv
// Self-checking bench for comparator_bist: behavioural faulty-comparator models, directed and random sweeps.
module tb_comparator_bist;

    localparam int W = 4;
    localparam int N = 1 << W;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           L, G, E;
    logic [W-1:0]   A, B;
    logic           busy, done, pass;
    logic [2*W:0]   err_count;
    logic [W-1:0]   fail_a, fail_b;

    int n_cmp = 0;
    int n_mis = 0;
    int mode  = 0;
    bit       fault_tbl [N*N];
    logic [2:0] fault_val [N*N];

    comparator_bist #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .L(L), .G(G), .E(E),
        .A(A), .B(B), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_a(fail_a), .fail_b(fail_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] ideal(input int a, input int b);
        return {a < b, a > b, a == b};
    endfunction

    // Comparator under test, returned as {L,G,E}
    function automatic logic [2:0] cmp_model(input int m, input int a, input int b);
        logic [2:0] r;
        r = ideal(a, b);
        case (m)
            1: r = r & 3'b110;
            2: if (a == 5 && b == 4) r = {r[1], r[2], r[0]};
            3: if (a == 10 && b == 10) r = 3'b101;
            4: if (fault_tbl[a*N+b]) r = fault_val[a*N+b];
            5: r = 3'b000;
            default: ;
        endcase
        return r;
    endfunction

    always_comb {L, G, E} = cmp_model(mode, int'(A), int'(B));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_A"}, int'(A), 0);
        chk({tag, "_B"}, int'(B), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_err"}, int'(err_count), 0);
        chk({tag, "_fa"}, int'(fail_a), 0);
        chk({tag, "_fb"}, int'(fail_b), 0);
    endtask

    task automatic run_sweep(input int m, input string tag, input int restart_at);
        int exp_err, first, cnt, order_err, exp_fa, exp_fb;
        mode = m;
        exp_err = 0;
        first = -1;
        for (int i = 0; i < N*N; i++) begin
            if (cmp_model(m, i / N, i % N) !== ideal(i / N, i % N)) begin
                exp_err++;
                if (first < 0) first = i;
            end
        end
        exp_fa = 0;
        exp_fb = 0;
`ifdef CMP_BIST_FAIL_CAPTURE_EN
        if (first >= 0) begin
            exp_fa = first / N;
            exp_fb = first % N;
        end
`endif
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_entry_busy"}, int'(busy), 1);
        chk({tag, "_entry_done"}, int'(done), 0);
        chk({tag, "_entry_err"}, int'(err_count), 0);
        chk({tag, "_entry_fa"}, int'(fail_a), 0);
        cnt = 0;
        order_err = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            if (int'(A) !== cnt / N || int'(B) !== cnt % N) order_err++;
            if (cnt == restart_at) start = 1'b1;
            step();
            start = 1'b0;
            cnt++;
        end
        chk({tag, "_len"}, cnt, N*N);
        chk({tag, "_order"}, order_err, 0);
        chk({tag, "_done"}, int'(done), 1);
        chk({tag, "_pass"}, int'(pass), (exp_err == 0) ? 1 : 0);
        chk({tag, "_err"}, int'(err_count), exp_err);
        chk({tag, "_A_hold"}, int'(A), N - 1);
        chk({tag, "_B_hold"}, int'(B), N - 1);
        chk({tag, "_fa"}, int'(fail_a), exp_fa);
        chk({tag, "_fb"}, int'(fail_b), exp_fb);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk_zero("reset");
        step();
        chk("idle_busy", int'(busy), 0);

        run_sweep(0, "good", -1);
        step(); step(); step();
        chk("done_hold", int'(done), 1);
        chk("done_hold_A", int'(A), N - 1);

        run_sweep(1, "e_stuck", -1);
        chk("e_stuck_16", int'(err_count), 16);

        run_sweep(2, "swap", -1);
        chk("swap_1", int'(err_count), 1);

        run_sweep(3, "l_and_e", -1);
        chk("l_and_e_1", int'(err_count), 1);
        chk("l_and_e_pass", int'(pass), 0);

        run_sweep(0, "restart_mid", 50);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N*N; i++) begin
                fault_tbl[i] = ($urandom_range(0, 15) == 0);
                fault_val[i] = ideal(i / N, i % N) ^ 3'($urandom_range(1, 7));
            end
            run_sweep(4, $sformatf("rand%0d", r), (r == 1) ? int'($urandom_range(1, 254)) : -1);
        end

        run_sweep(5, "all_fail", -1);
        chk("all_fail_max", int'(err_count), N*N);

        mode = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100; i++) step();
        chk("mid_busy", int'(busy), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_zero("mid_reset");
        for (int i = 0; i < 5; i++) step();
        chk("post_reset_busy", int'(busy), 0);
        chk("post_reset_done", int'(done), 0);
        run_sweep(0, "after_reset", -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/comparator_bist.md
COMPARATOR_BIST -- requirements
Module: comparator_bist

Interface
REQ-001 Parameter W, default 4: operand width driven to the comparator under test.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin an exhaustive sweep.
REQ-005 L  input  1  comparator result, A<B.
REQ-006 G  input  1  comparator result, A>B.
REQ-007 E  input  1  comparator result, A==B.
REQ-008 A  output  W  operand A driven to the comparator, registered.
REQ-009 B  output  W  operand B driven to the comparator, registered.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  high from sweep completion until the next accepted start or reset.
REQ-012 pass  output  1  valid while done is high; 1 when err_count==0.
REQ-013 err_count  output  2W+1  number of failing vectors in the current or last sweep.
REQ-014 fail_a, fail_b  output  W each  operands of the first failing vector (see REQ-030).

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 IDLE->RUN on start==1; DONE->RUN on start==1; RUN->DONE after the last vector is checked; no other transitions except reset.
REQ-017 start in RUN SHALL be ignored.
REQ-018 On entry to RUN: A=0, B=0, err_count=0, done=0; the first vector is driven in the first RUN cycle.
REQ-019 Sweep order: B is the inner index, A the outer; B increments every RUN cycle; at B=2^W-1, B wraps to 0 and A increments.
REQ-020 The comparator is combinational, so each vector's L/G/E SHALL be sampled on the clock edge ending the cycle in which that vector is driven; no extra settle cycle.
REQ-021 Expected result: L=(A<B), G=(A>B), E=(A==B), unsigned.
REQ-022 A vector fails if any of L/G/E differs from expected; this includes non-one-hot codes (none or several asserted).
REQ-023 Each failing vector SHALL increment err_count by 1; max 2^(2W), never wraps.
REQ-024 RUN SHALL last exactly 2^(2W) cycles (256 for W=4); after the vector A=B=2^W-1 is checked, the next state is DONE.
REQ-025 In DONE: busy=0, done=1, pass=(err_count==0); A and B hold 2^W-1.
REQ-026 busy=1 exactly while in RUN.
REQ-027 A start accepted in DONE SHALL clear done, err_count and the fail capture in the same edge that enters RUN.

Reset
REQ-028 When rst_n==0 at a clock edge, the state SHALL go to IDLE and A, B, busy, done, pass, err_count, fail_a and fail_b SHALL all be 0.
REQ-029 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; a fresh start SHALL be required.

Configuration
REQ-030 With macro CMP_BIST_FAIL_CAPTURE_EN defined, fail_a/fail_b SHALL latch A/B of the first failing vector of each sweep and hold until the next accepted start or reset.
REQ-031 Without CMP_BIST_FAIL_CAPTURE_EN, fail_a and fail_b SHALL be tied to 0 and no capture registers SHALL be built; all other behaviour is unchanged.

Verification
REQ-032 Correct comparator model, reset, then start pulse -> busy for 256 cycles; done=1, pass=1, err_count=0; A=B=4'b1111 held.
REQ-033 Model with E stuck at 0 -> err_count=16, pass=0; with capture enabled fail_a=0, fail_b=0.
REQ-034 Model swapping L and G only when A=4'b0101 and B=4'b0100 -> err_count=1; with capture enabled fail_a=4'b0101, fail_b=4'b0100.
REQ-035 Model asserting L and E together when A=4'b1010 and B=4'b1010 -> err_count=1, pass=0.
REQ-036 rst_n low for 1 cycle at RUN cycle 100 -> all outputs 0 next cycle and state IDLE; a later start runs a full 256-cycle sweep.
REQ-037 start re-pulsed mid-RUN -> ignored and sweep length still 256; start in DONE -> done=0 and err_count=0 on the next cycle.
